// File: rtl/phy_pkg.sv
// phy_pkg: word format, lock states and slot-to-lane map shared by the phy tx and rx paths
package phy_pkg;
    localparam int WORD_W = 9;
    localparam int VALID_BIT = 8;
    localparam logic [WORD_W-1:0] IDLE_WORD = 9'h000;
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    // two bits per slot, slot 0 in the LSBs: slots 0..3 carry lanes 0,2,1,3
    localparam logic [7:0] LANE_MAP = {2'd3, 2'd1, 2'd2, 2'd0};
endpackage

// File: rtl/mux_4to1_serial.sv
// mux_4to1_serial: 4:1 word serializer with strobe alignment tracking
module mux_4to1_serial #(
    parameter int WIDTH = phy_pkg::WORD_W,
    parameter logic [WIDTH-1:0] IDLE_WORD = phy_pkg::IDLE_WORD
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             sync_in,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [WIDTH-1:0] outSerial,
    output logic [1:0]       out_phase,
    output logic             locked,
    output logic             sync_err
);
    import phy_pkg::*;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_hold [4];
    logic [WIDTH-1:0] r_out, w_out;
    logic [1:0]       r_slot, w_slot, r_phase, w_phase, w_lane;
    logic             r_err, w_err, w_run;

    // w_run: mid-frame, still emitting words of the held frame
    always_comb begin
        w_lane  = LANE_MAP[{r_slot, 1'b0} +: 2];
        w_run   = r_state == LOCKED && r_slot != 2'd0;
        w_err   = r_state == LOCKED && (sync_in ? r_slot != 2'd0 : r_slot == 2'd0);
        w_state = (sync_in || w_run) ? LOCKED : UNLOCKED;
        w_slot  = sync_in ? 2'd1 : w_run ? r_slot + 2'd1 : 2'd0;
        w_out   = sync_in ? data0 : w_run ? r_hold[w_lane] : IDLE_WORD;
        w_phase = sync_in ? 2'd0 : w_run ? r_slot : 2'd0;
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state <= UNLOCKED;
            r_slot  <= 2'd0;
            r_out   <= IDLE_WORD;
            r_phase <= 2'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) r_hold[i] <= '0;
        end else begin
            r_state <= w_state;
            r_slot  <= w_slot;
            r_out   <= w_out;
            r_phase <= w_phase;
            r_err   <= w_err;
            if (sync_in) begin
                r_hold[0] <= data0;
                r_hold[1] <= data1;
                r_hold[2] <= data2;
                r_hold[3] <= data3;
            end
        end
    end

    assign outSerial = r_out;
    assign out_phase = r_phase;
    assign locked    = r_state == LOCKED;
    assign sync_err  = r_err;
endmodule

// File: tb/tb_mux_4to1_serial.sv
// tb_mux_4to1_serial: scoreboard bench; each driven cycle queues the outputs expected after its edge
module tb_mux_4to1_serial;
    logic       clk_4f = 1'b0;
    logic       reset = 1'b1;
    logic       sync_in = 1'b0;
    logic [8:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
    logic [8:0] outSerial;
    logic [1:0] out_phase;
    logic       locked, sync_err;
    logic [12:0] q [$];
    logic [12:0] exp_v;
    int n_tests = 0;
    int n_fail = 0;

    mux_4to1_serial dut (
        .clk_4f(clk_4f), .reset(reset), .sync_in(sync_in),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .outSerial(outSerial), .out_phase(out_phase), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h ph=%0d lk=%b err=%b, want out=%h ph=%0d lk=%b err=%b",
                     tag, got[12:4], got[3:2], got[1], got[0], exp[12:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    always @(posedge clk_4f) begin
        #1;
        if (q.size() != 0) begin
            exp_v = q.pop_front();
            check($sformatf("cyc@%0t", $time), {outSerial, out_phase, locked, sync_err}, exp_v);
        end
    end

    // non-capture cycles drive random data, which must not reach the output
    task automatic tick(input logic s, input logic r, input logic [8:0] a, b, c, d,
                        input logic [8:0] eo, input logic [1:0] ep, input logic el, input logic ee);
        @(negedge clk_4f);
        reset = r;
        sync_in = s;
        data0 = s ? a : 9'($urandom);
        data1 = s ? b : 9'($urandom);
        data2 = s ? c : 9'($urandom);
        data3 = s ? d : 9'($urandom);
        q.push_back({eo, ep, el, ee});
    endtask

    task automatic idle(input logic r);
        tick(1'b0, r, 9'h0, 9'h0, 9'h0, 9'h0, 9'h000, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [8:0] a, b, c, d, input logic e0);
        tick(1'b1, 1'b0, a, b, c, d, a, 2'd0, 1'b1, e0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, c, 2'd1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, b, 2'd2, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, d, 2'd3, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 2'd0, 1'b0, 1'b0);
        frame(9'h101, 9'h102, 9'h103, 9'h104, 1'b0);
        frame(9'h1A5, 9'h1A6, 9'h1A7, 9'h1A8, 1'b0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h000, 2'd0, 1'b0, 1'b1);
        idle(1'b0);
        frame(9'h055, 9'h0AA, 9'h1C3, 9'h13C, 1'b0);
        tick(1'b1, 1'b0, 9'h011, 9'h022, 9'h033, 9'h044, 9'h011, 2'd0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h033, 2'd1, 1'b1, 1'b0);
        frame(9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4, 1'b1);
        tick(1'b1, 1'b0, 9'h181, 9'h182, 9'h183, 9'h184, 9'h181, 2'd0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h183, 2'd1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 9'h1EE, 9'h1EE, 9'h1EE, 9'h1EE, 9'h000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        @(negedge clk_4f);
        @(negedge clk_4f);
        if (q.size() != 0) check("drain", 13'(q.size()), 13'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
